// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed four-digit 7-segment driver.
// Segment patterns are active-low {DP,g,f,e,d,c,b,a}; bit 7 is kept at 1 (DP off).
package seg7_pkg;

    localparam logic [7:0] SEG_HEX_0 = 8'hC0;
    localparam logic [7:0] SEG_HEX_1 = 8'hF9;
    localparam logic [7:0] SEG_HEX_2 = 8'hA4;
    localparam logic [7:0] SEG_HEX_3 = 8'hB0;
    localparam logic [7:0] SEG_HEX_4 = 8'h99;
    localparam logic [7:0] SEG_HEX_5 = 8'h92;
    localparam logic [7:0] SEG_HEX_6 = 8'h82;
    localparam logic [7:0] SEG_HEX_7 = 8'hF8;
    localparam logic [7:0] SEG_HEX_8 = 8'h80;
    localparam logic [7:0] SEG_HEX_9 = 8'h90;
    localparam logic [7:0] SEG_HEX_A = 8'h88;
    localparam logic [7:0] SEG_HEX_B = 8'h83;
    localparam logic [7:0] SEG_HEX_C = 8'hC6;
    localparam logic [7:0] SEG_HEX_D = 8'hA1;
    localparam logic [7:0] SEG_HEX_E = 8'h86;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] ANODE_RST = 4'b1110;

    typedef logic [1:0] dig_t;
    localparam dig_t DIG_LAST = 2'd3;

    // One displayable frame: four hex nibbles plus their decimal points.
    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
    } disp_word_t;

    // Active-low anode for digit d: the reset pattern rotated left by d.
    function automatic logic [3:0] anode_for(input dig_t d);
        logic [7:0] rot;
        rot = {ANODE_RST, ANODE_RST} << d;
        return rot[7:4];
    endfunction

endpackage

// File: rtl/seg7_scan_drv_if.sv
// Valid/ready value port between the counter stage (master) and the display driver (slave).
interface seg7_scan_drv_if;
    logic [15:0] VAL;
    logic [3:0]  DP_IN;
    logic        VAL_VLD;
    logic        VAL_RDY;

    modport master (output VAL, output DP_IN, output VAL_VLD, input VAL_RDY);
    modport slave  (input VAL, input DP_IN, input VAL_VLD, output VAL_RDY);
endinterface

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex7seg_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        seg_o = SEG_HEX_0[6:0];
        case (nib_i)
            4'h0: seg_o = SEG_HEX_0[6:0];
            4'h1: seg_o = SEG_HEX_1[6:0];
            4'h2: seg_o = SEG_HEX_2[6:0];
            4'h3: seg_o = SEG_HEX_3[6:0];
            4'h4: seg_o = SEG_HEX_4[6:0];
            4'h5: seg_o = SEG_HEX_5[6:0];
            4'h6: seg_o = SEG_HEX_6[6:0];
            4'h7: seg_o = SEG_HEX_7[6:0];
            4'h8: seg_o = SEG_HEX_8[6:0];
            4'h9: seg_o = SEG_HEX_9[6:0];
            4'hA: seg_o = SEG_HEX_A[6:0];
            4'hB: seg_o = SEG_HEX_B[6:0];
            4'hC: seg_o = SEG_HEX_C[6:0];
            4'hD: seg_o = SEG_HEX_D[6:0];
            4'hE: seg_o = SEG_HEX_E[6:0];
            4'hF: seg_o = SEG_HEX_F[6:0];
            default: seg_o = SEG_HEX_0[6:0];
        endcase
    end

endmodule

// File: rtl/seg7_scan_drv.sv
// Four-digit multiplexed common-anode 7-segment driver with frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_drv
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    seg7_scan_drv_if.slave        bus,
    output logic                  FRAME,
    output logic [11:0]           SEG
);

    localparam int               CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dig_t             dig_q, dig_d;
    disp_word_t       disp_q, disp_d;
    disp_word_t       pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             frame_q, frame_d;

    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        dig_d       = dig_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        frame_d     = 1'b0;

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
            // Frame boundary: only here may the displayed value change.
            if (dig_q == DIG_LAST) begin
                frame_d = 1'b1;
                if (pend_full_q) begin
                    disp_d      = pend_q;
                    pend_full_d = 1'b0;
                end
            end
        end

        // Accept only into an empty slot, so this never collides with the boundary copy.
        if (bus.VAL_VLD && !pend_full_q) begin
            pend_d      = '{val: bus.VAL, dp: bus.DP_IN};
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt_q       <= '0;
            dig_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge state.
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.VAL_RDY = ~pend_full_q;
    assign FRAME       = frame_q;

    logic [3:0] cur_nib;
    logic [6:0] hex_seg;
    logic [6:0] cath;

    assign cur_nib = disp_q.val[{dig_q, 2'b00} +: 4];

    hex7seg_dec u_dec (
        .nib_i (cur_nib),
        .seg_o (hex_seg)
    );

`ifdef SEG7_LZB_EN
    logic [3:0] blank;

    // Digit n blanks when it and every digit to its left are zero; digit 0 always shows.
    always_comb begin
        blank[3] = (disp_q.val[15:12] == 4'h0);
        blank[2] = blank[3] && (disp_q.val[11:8] == 4'h0);
        blank[1] = blank[2] && (disp_q.val[7:4] == 4'h0);
        blank[0] = 1'b0;
    end

    assign cath = blank[dig_q] ? SEG_BLANK[6:0] : hex_seg;
`else
    assign cath = hex_seg;
`endif

    assign SEG = {anode_for(dig_q), ~disp_q.dp[dig_q], cath};

endmodule

// File: doc/seg7_scan_drv.md
# seg7_scan_drv

Multiplexed driver for the four-digit common-anode 7-segment display on the board. It takes the 16-bit hex value produced by the counter stage through a valid/ready handshake and decodes each nibble to a segment pattern. It time-multiplexes the four digits and drives the 12-bit `SEG` bus (cathodes plus anodes) at the top level. New values are held back until a frame boundary, so a frame never shows a mix of old and new digits.

## Interface
- `SCAN_DIV`, 100_000: clock cycles each digit stays lit; legal range is ≥ 2.
- `CLK` in 1: the single clock for the block.
- `RESET_N` in 1: reset, synchronous, active-low.
- `VAL` in 16: hex value; `VAL[3:0]` is digit 0 (rightmost).
- `DP_IN` in 4: per-digit decimal point, 1 = lit; sampled together with `VAL`.
- `VAL_VLD` in 1: `VAL`/`DP_IN` valid.
- `VAL_RDY` out 1: block can accept a new value.
- `FRAME` out 1: one-cycle pulse when digit 0 becomes active.
- `SEG` out 12: `[7:0]` = {DP,g,f,e,d,c,b,a}, active-low; `[11:8]` = anodes, active-low, bit n = digit n.

## Operation
- State:
  - Prescaler `CNT` counts 0..SCAN_DIV-1.
  - 2-bit digit index `DIG`.
  - Display register `DISP` holds 16-bit value + 4-bit DP.
  - Pending register `PEND` holds value + DP, with a full flag.
- Reset values:
  - `CNT`=0, `DIG`=0, `DISP`=0 with DP=0, `PEND` empty.
  - Outputs: `VAL_RDY`=1, `FRAME`=0, `SEG`=12'hEC0 (anode 1110, digit 0 shows "0").
- Scan:
  - When `CNT`==SCAN_DIV-1: `CNT`←0 and `DIG`←`DIG`+1, wrapping 3→0.
  - Otherwise `CNT`←`CNT`+1.
- Anodes: `SEG[11:8]` = ~(1<<`DIG`). Sequence is 1110 → 1101 → 1011 → 0111 → 1110.
- Cathodes:
  - `SEG[6:0]` = hex pattern of `DISP` nibble `DIG`. Patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (bit 7 shown as 1).
  - `SEG[7]` = ~DP of digit `DIG`.
  - `SEG` is combinational from registered `DIG`/`DISP` only. Anodes and cathodes change on the same edge.
- Handshake:
  - `VAL_RDY` = ~`PEND`.full.
  - Transfer occurs when `VAL_VLD`&&`VAL_RDY` at a rising edge; `VAL`/`DP_IN` go into `PEND`, full←1.
  - `VAL_VLD` while `VAL_RDY`=0 is ignored. Upstream holds `VAL` until accepted. No data is dropped silently.
- Frame boundary is the edge where `DIG` wraps 3→0:
  - `FRAME`←1 for that one cycle.
  - If `PEND` is full: `DISP`←`PEND` and full←0.
  - If `PEND` is empty: `DISP` is unchanged.
- Simultaneous events: a transfer can only happen while `PEND` is empty, so it never collides with the boundary copy. A value accepted on the boundary edge is shown from the following frame.
- Reset asserted mid-operation restores all reset values at the next edge. A pending value is discarded.

## Timing
- Each digit dwell is exactly SCAN_DIV cycles; a frame is 4×SCAN_DIV cycles.
- `FRAME` period is 4×SCAN_DIV cycles. The first `FRAME` after reset release comes 4×SCAN_DIV cycles after the first non-reset edge.
- Accept-to-display latency ranges from 1 cycle to 4×SCAN_DIV cycles, depending on frame phase.
- `VAL_RDY` rises on the boundary edge that empties `PEND`. The next transfer is possible in the following cycle.
- Throughput is at most one value per frame.

## Configuration
- `SEG7_LZB_EN` defined: leading-zero blanking.
  - Digit n (n = 3..1) is blanked when `DISP` nibbles n..3 are all zero.
  - A blanked digit shows `SEG[6:0]`=7'h7F; its DP is still honoured.
  - Digit 0 is never blanked.
  - Anode scanning is unchanged, so dwell stays uniform.
- `SEG7_LZB_EN` not defined: all four digits always show their hex pattern.

## Structure
- Package `seg7_pkg`:
  - 16 hex pattern constants.
  - `SEG_BLANK`=8'hFF.
  - `ANODE_RST`=4'b1110.
  - Digit-index type (2 bits).
- Sub-module `hex7seg_dec`: purely combinational, 4-bit nibble → 7-bit active-low pattern, one instance on the muxed nibble.
- Top-level integration: `SEG` connects straight to the board `SEG` pins. The counter output drives `VAL`, with `VAL_VLD` tied 1.

## Test plan
Benches use SCAN_DIV=4.
- Reset: `RESET_N`=0 for 3 cycles → `SEG`=12'hEC0, `VAL_RDY`=1, `FRAME`=0.
- Scan: idle for 48 cycles → anodes step 1110/1101/1011/0111, 4 cycles each. `FRAME` pulses at cycles 16, 32, 48 after release.
- Handshake: `VAL`=16'h1234, `VAL_VLD`=1 for 1 cycle at frame cycle 5.
  - `VAL_RDY`=0 from the next cycle.
  - Digit 0 still C0 until `FRAME`, then digits 0..3 show 99, B0, A4, F9.
  - `VAL_RDY`=1 at the `FRAME` edge.
- Back-pressure: second `VAL`=16'hABCD with `VAL_VLD` while `VAL_RDY`=0, held.
  - Not shown in the next frame.
  - Accepted 1 cycle after that `FRAME`.
  - Shows 86? no: digit 0 = A1 (d), digit 3 = 88 (A), one frame later.
- Blanking: `VAL`=16'h0050 with `DP_IN`=4'b0001.
  - With `SEG7_LZB_EN`: digits 3, 2 = 8'hFF, digit 1 = 8'h92, digit 0 = 8'h40.
  - Without `SEG7_LZB_EN`: digits 3, 2 = 8'hC0.
- Mid-frame reset with `PEND` full → `SEG`=12'hEC0, `VAL_RDY`=1. The pending value is never displayed.
